// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the memory req/ack handshake and feeds the IR.
// Optional bus-timeout watchdog is compiled in with `define IFU_TIMEOUT_EN.
module instr_fetch_unit #(
    parameter int unsigned           ADDR_W   = 32,
    parameter int unsigned           DATA_W   = 32,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0,
    parameter int unsigned           PC_INC   = 4
`ifdef IFU_TIMEOUT_EN
    ,
    parameter int unsigned           TIMEOUT  = 16
`endif
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Fetch_En,
    input  logic              Stall,
    input  logic              Branch_Tkn,
    input  logic [ADDR_W-1:0] Branch_Addr,
    output logic              Mem_Req,
    output logic [ADDR_W-1:0] Mem_Addr,
    input  logic              Mem_Ack,
    input  logic [DATA_W-1:0] Mem_Data,
    output logic [DATA_W-1:0] Out_Inst,
    output logic [ADDR_W-1:0] Inst_PC,
    output logic              IR_Ld,
    output logic [ADDR_W-1:0] PC_Out,
    output logic              Fetch_Err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] out_inst_q;
    logic [ADDR_W-1:0] inst_pc_q;
    logic              discard_q;
    logic              err_lock;
    logic              timeout_hit;
    logic [ADDR_W-1:0] pc_seq_d;

    assign pc_seq_d = pc_q + ADDR_W'(PC_INC);

`ifdef IFU_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             fetch_err_q;

    // Counts consecutive ack-less REQ cycles; any other cycle (including REQ entry) clears it.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q == REQ && !Mem_Ack) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    assign timeout_hit = (state_q == REQ) && !Mem_Ack && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            fetch_err_q <= 1'b0;
        end else if (timeout_hit) begin
            fetch_err_q <= 1'b1;
        end
    end

    assign err_lock = fetch_err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_lock    = 1'b0;
`endif

    // A branch in HOLD kills the held instruction even when the IR is ready.
    assign IR_Ld     = (state_q == HOLD) && !Stall && !Branch_Tkn;
    assign Mem_Req   = (state_q == REQ);
    assign Mem_Addr  = mem_addr_q;
    assign Out_Inst  = out_inst_q;
    assign Inst_PC   = inst_pc_q;
    assign PC_Out    = pc_q;
    assign Fetch_Err = err_lock;

    // NOTE: all state is updated with non-blocking assignments so every branch of the
    // case reads the pre-edge values; a later assignment in the same block overrides an earlier one.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            mem_addr_q <= RESET_PC;
            out_inst_q <= '0;
            inst_pc_q  <= '0;
            discard_q  <= 1'b0;
        end else begin
            if (Branch_Tkn) begin
                pc_q <= Branch_Addr;
            end

            unique case (state_q)
                IDLE: begin
                    if (Fetch_En && !err_lock) begin
                        state_q    <= REQ;
                        mem_addr_q <= Branch_Tkn ? Branch_Addr : pc_q;
                    end
                end

                REQ: begin
                    if (Mem_Ack) begin
                        if (Branch_Tkn || discard_q) begin
                            discard_q  <= 1'b0;
                            mem_addr_q <= Branch_Tkn ? Branch_Addr : pc_q;
                        end else begin
                            out_inst_q <= Mem_Data;
                            inst_pc_q  <= mem_addr_q;
                            pc_q       <= pc_seq_d;
                            state_q    <= HOLD;
                        end
                    end else begin
                        if (Branch_Tkn) begin
                            discard_q <= 1'b1;
                        end
                        if (timeout_hit) begin
                            discard_q <= 1'b0;
                            state_q   <= IDLE;
                        end
                    end
                end

                HOLD: begin
                    if (Branch_Tkn) begin
                        state_q    <= Fetch_En ? REQ : IDLE;
                        mem_addr_q <= Branch_Addr;
                    end else if (!Stall) begin
                        state_q    <= Fetch_En ? REQ : IDLE;
                        mem_addr_q <= pc_q;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, stall, branch/flush, PC wrap,
// reset mid-request and the bus timeout (IFU_TIMEOUT_EN build) or its absence.
module tb_instr_fetch_unit;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Fetch_En;
    logic        Stall;
    logic        Branch_Tkn;
    logic [31:0] Branch_Addr;
    logic        Mem_Req;
    logic [31:0] Mem_Addr;
    logic        Mem_Ack;
    logic [31:0] Mem_Data;
    logic [31:0] Out_Inst;
    logic [31:0] Inst_PC;
    logic        IR_Ld;
    logic [31:0] PC_Out;
    logic        Fetch_Err;

    int n_vec = 0;
    int n_err = 0;

    instr_fetch_unit dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Fetch_En   (Fetch_En),
        .Stall      (Stall),
        .Branch_Tkn (Branch_Tkn),
        .Branch_Addr(Branch_Addr),
        .Mem_Req    (Mem_Req),
        .Mem_Addr   (Mem_Addr),
        .Mem_Ack    (Mem_Ack),
        .Mem_Data   (Mem_Data),
        .Out_Inst   (Out_Inst),
        .Inst_PC    (Inst_PC),
        .IR_Ld      (IR_Ld),
        .PC_Out     (PC_Out),
        .Fetch_Err  (Fetch_Err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory answers this cycle (only if a request is up) with data = address ^ K, then one clock.
    task automatic cyc(input logic ack);
        Mem_Ack  = ack & Mem_Req;
        Mem_Data = Mem_Addr ^ K;
        @(posedge Clk);
        #1;
        Mem_Ack  = 1'b0;
    endtask

    initial begin
        Rst_n = 1'b0; Fetch_En = 1'b0; Stall = 1'b0; Branch_Tkn = 1'b0;
        Branch_Addr = '0; Mem_Ack = 1'b0; Mem_Data = '0;
        #1;
        check("rst_req",    {31'd0, Mem_Req},   32'd0);
        check("rst_irld",   {31'd0, IR_Ld},     32'd0);
        check("rst_pc",     PC_Out,             32'd0);
        check("rst_addr",   Mem_Addr,           32'd0);
        check("rst_inst",   Out_Inst,           32'd0);
        check("rst_ipc",    Inst_PC,            32'd0);
        check("rst_err",    {31'd0, Fetch_Err}, 32'd0);
        @(posedge Clk); @(posedge Clk); #1;
        Rst_n = 1'b1;

        // Sequential fetch at one instruction per two cycles.
        Fetch_En = 1'b1;
        cyc(1'b1);
        check("t1_req0",   {31'd0, Mem_Req}, 32'd1);
        check("t1_addr0",  Mem_Addr,         32'h0);
        check("t1_nold0",  {31'd0, IR_Ld},   32'd0);
        cyc(1'b1);
        check("t1_ld0",    {31'd0, IR_Ld},   32'd1);
        check("t1_inst0",  Out_Inst,         32'hA5A5_0000);
        check("t1_ipc0",   Inst_PC,          32'h0);
        check("t1_pc0",    PC_Out,           32'h4);
        check("t1_noreq",  {31'd0, Mem_Req}, 32'd0);
        cyc(1'b1);
        check("t1_addr1",  Mem_Addr,         32'h4);
        check("t1_nold1",  {31'd0, IR_Ld},   32'd0);
        cyc(1'b1);
        check("t1_ld1",    {31'd0, IR_Ld},   32'd1);
        check("t1_inst1",  Out_Inst,         32'hA5A5_0004);
        check("t1_ipc1",   Inst_PC,          32'h4);
        cyc(1'b1);
        cyc(1'b1);
        check("t1_ld2",    {31'd0, IR_Ld},   32'd1);
        check("t1_inst2",  Out_Inst,         32'hA5A5_0008);
        check("t1_ipc2",   Inst_PC,          32'h8);

        // IR back-pressure while holding instruction @8.
        Stall = 1'b1;
        #1;
        check("t2_stall_ld", {31'd0, IR_Ld}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1);
            check("t2_hold_ld",   {31'd0, IR_Ld},   32'd0);
            check("t2_hold_inst", Out_Inst,         32'hA5A5_0008);
            check("t2_hold_req",  {31'd0, Mem_Req}, 32'd0);
        end
        Stall = 1'b0;
        #1;
        check("t2_release_ld", {31'd0, IR_Ld}, 32'd1);
        cyc(1'b1);
        check("t2_next_addr",  Mem_Addr,        32'hC);
        check("t2_single_ld",  {31'd0, IR_Ld},  32'd0);

        // Branch during REQ, memory answers three cycles later: answer is discarded.
        Branch_Addr = 32'h100; Branch_Tkn = 1'b1;
        cyc(1'b0);
        Branch_Tkn = 1'b0;
        check("t3_pc",       PC_Out,           32'h100);
        check("t3_addr_old", Mem_Addr,         32'hC);
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
        check("t3_drop_req",  {31'd0, Mem_Req}, 32'd1);
        check("t3_drop_addr", Mem_Addr,         32'h100);
        check("t3_drop_ld",   {31'd0, IR_Ld},   32'd0);
        check("t3_drop_ipc",  Inst_PC,          32'h8);
        cyc(1'b1);
        check("t3_ld",   {31'd0, IR_Ld}, 32'd1);
        check("t3_ipc",  Inst_PC,        32'h100);
        check("t3_inst", Out_Inst,       32'hA5A5_0100);

        // Branch in HOLD with Stall=0: held instruction not loaded.
        Branch_Addr = 32'h200; Branch_Tkn = 1'b1;
        #1;
        check("t4_kill_ld", {31'd0, IR_Ld}, 32'd0);
        cyc(1'b0);
        Branch_Tkn = 1'b0;
        check("t4_addr", Mem_Addr,         32'h200);
        check("t4_req",  {31'd0, Mem_Req}, 32'd1);
        check("t4_ipc",  Inst_PC,          32'h100);
        // Branch coincident with the memory answer.
        Branch_Addr = 32'h300; Branch_Tkn = 1'b1;
        cyc(1'b1);
        Branch_Tkn = 1'b0;
        check("t4b_addr", Mem_Addr,         32'h300);
        check("t4b_req",  {31'd0, Mem_Req}, 32'd1);
        check("t4b_ipc",  Inst_PC,          32'h100);
        check("t4b_ld",   {31'd0, IR_Ld},   32'd0);
        cyc(1'b1);
        check("t4b_ipc2", Inst_PC,  32'h300);
        check("t4b_inst", Out_Inst, 32'hA5A5_0300);

        // PC wrap at the top of the address space.
        Branch_Addr = 32'hFFFF_FFFC; Branch_Tkn = 1'b1;
        cyc(1'b0);
        Branch_Tkn = 1'b0;
        check("t5_addr_top", Mem_Addr, 32'hFFFF_FFFC);
        cyc(1'b1);
        check("t5_ipc_top",  Inst_PC,  32'hFFFF_FFFC);
        check("t5_inst_top", Out_Inst, 32'h5A5A_FFFC);
        check("t5_pc_wrap",  PC_Out,   32'h0);
        cyc(1'b1);
        cyc(1'b1);
        check("t5_ipc_zero",  Inst_PC,  32'h0);
        check("t5_inst_zero", Out_Inst, 32'hA5A5_0000);

        // Fetch_En dropped with a request outstanding: it completes, then IDLE.
        cyc(1'b0);
        check("t5_addr4", Mem_Addr, 32'h4);
        Fetch_En = 1'b0;
        cyc(1'b1);
        check("t5_last_ld",  {31'd0, IR_Ld}, 32'd1);
        check("t5_last_ipc", Inst_PC,        32'h4);
        cyc(1'b0);
        check("t5_idle_req", {31'd0, Mem_Req}, 32'd0);
        check("t5_idle_ld",  {31'd0, IR_Ld},   32'd0);
        check("t5_idle_pc",  PC_Out,           32'h8);
        cyc(1'b0);
        check("t5_idle_req2", {31'd0, Mem_Req}, 32'd0);

        // Reset in the middle of a request.
        Fetch_En = 1'b1;
        cyc(1'b0);
        check("t5_mid_req", {31'd0, Mem_Req}, 32'd1);
        check("t5_mid_addr", Mem_Addr,        32'h8);
        Fetch_En = 1'b0;
        Rst_n = 1'b0;
        #1;
        check("t5r_req",  {31'd0, Mem_Req}, 32'd0);
        check("t5r_addr", Mem_Addr,         32'h0);
        check("t5r_pc",   PC_Out,           32'h0);
        check("t5r_inst", Out_Inst,         32'h0);
        check("t5r_ipc",  Inst_PC,          32'h0);
        check("t5r_ld",   {31'd0, IR_Ld},   32'd0);
        @(posedge Clk); #1;
        Rst_n = 1'b1;

        // Memory never answers.
        Fetch_En = 1'b1;
        cyc(1'b0);
        check("t6_enter", {31'd0, Mem_Req}, 32'd1);
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0);
            check("t6_wait_req", {31'd0, Mem_Req},   32'd1);
            check("t6_wait_err", {31'd0, Fetch_Err}, 32'd0);
        end
        cyc(1'b0);
`ifdef IFU_TIMEOUT_EN
        check("t6_tmo_req", {31'd0, Mem_Req},   32'd0);
        check("t6_tmo_err", {31'd0, Fetch_Err}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0);
            check("t6_lock_req", {31'd0, Mem_Req},   32'd0);
            check("t6_lock_err", {31'd0, Fetch_Err}, 32'd1);
        end
`else
        check("t6_noto_req", {31'd0, Mem_Req},   32'd1);
        check("t6_noto_err", {31'd0, Fetch_Err}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0);
            check("t6_wait_more", {31'd0, Mem_Req}, 32'd1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
